// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps a blink, chase, bounce or bar-fill pattern
// once per tick_enable strobe while run is high, with a pattern-wrap strobe.
module led_pattern_sequencer #(
    parameter int LED_COUNT = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 tick_enable,
    input  logic                 run,
    input  logic [1:0]           mode,
    output logic [LED_COUNT-1:0] led_out,
    output logic                 pattern_wrap
);

    localparam int PW = $clog2(LED_COUNT + 1);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [PW-1:0] POS_LAST = PW'(LED_COUNT - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(LED_COUNT);

    typedef enum logic [1:0] {
        M_BLINK  = 2'd0,
        M_CHASE  = 2'd1,
        M_BOUNCE = 2'd2,
        M_FILL   = 2'd3
    } mode_t;

    mode_t                mode_q, mode_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 dir_down_q, dir_down_d;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic                 wrap_q, wrap_d;

    logic                 step;
    logic                 restart;
    mode_t                mode_in;
    logic [LED_COUNT-1:0] chase_vec;
    logic [LED_COUNT-1:0] fill_vec;

    assign step    = tick_enable & run;
    assign mode_in = mode_t'(mode);

    // Per-LED decode of the next position: one-hot for chase/bounce, thermometer for fill
    for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_decode
        localparam logic [PW-1:0] IDX = PW'(gi);
        assign chase_vec[gi] = (pos_d == IDX);
        assign fill_vec[gi]  = (pos_d > IDX);
    end

    // Next-state: mode switch restarts the pattern, otherwise advance the current one
    always_comb begin
        mode_d     = mode_q;
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        wrap_d     = 1'b0;
        restart    = 1'b0;
        if (step) begin
            if (mode_in != mode_q) begin
                mode_d  = mode_in;
                restart = 1'b1;
            end else begin
                case (mode_q)
                    M_BLINK: begin
                        // position 0 = all off, 1 = all on
                        if (pos_q == '0) begin
                            pos_d = POS_ONE;
                        end else if (pos_q == POS_ONE) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            restart = 1'b1;
                        end
                    end
                    M_CHASE: begin
                        if (pos_q < POS_LAST) begin
                            pos_d = pos_q + 1'b1;
                        end else if (pos_q == POS_LAST) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            restart = 1'b1;
                        end
                    end
                    M_BOUNCE: begin
                        // Direction flips on arrival at an end, so each end shows once per pass
                        if (pos_q > POS_LAST) begin
                            restart = 1'b1;
                        end else if (!dir_down_q) begin
                            if (pos_q == POS_LAST) begin
                                restart = 1'b1;
                            end else begin
                                pos_d      = pos_q + 1'b1;
                                dir_down_d = (pos_q + 1'b1 == POS_LAST);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                restart = 1'b1;
                            end else begin
                                pos_d = pos_q - 1'b1;
                                if (pos_q == POS_ONE) begin
                                    dir_down_d = 1'b0;
                                    wrap_d     = 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        if (pos_q < POS_FULL) begin
                            pos_d = pos_q + 1'b1;
                        end else if (pos_q == POS_FULL) begin
                            pos_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            restart = 1'b1;
                        end
                    end
                endcase
            end
            if (restart) begin
                pos_d      = '0;
                dir_down_d = 1'b0;
                wrap_d     = 1'b0;
            end
        end
    end

    // LED image for the next state; held unchanged when no step occurs
    always_comb begin
        led_d = led_q;
        if (step) begin
            case (mode_d)
                M_BLINK:  led_d = {LED_COUNT{pos_d == POS_ONE}};
                M_CHASE:  led_d = chase_vec;
                M_BOUNCE: led_d = chase_vec;
                default:  led_d = fill_vec;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            mode_q     <= M_BLINK;
            pos_q      <= '0;
            dir_down_q <= 1'b0;
            led_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            led_q      <= led_d;
            wrap_q     <= wrap_d;
        end
    end

    assign led_out      = led_q;
    assign pattern_wrap = wrap_q;

endmodule
